// File: rtl/gate_vector_tester.sv
// Self-test sequencer: steps a 3-input gate stage through all 8 vectors,
// compares its 9-bit result against a golden model and reports the outcome.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          synchronous active-low reset
//   start            begin a run (honoured in IDLE and DONE only)
//   result[8:0]      output vector of the gate stage under test
//   input1..input3   stimulus to the gate stage (vec[2], vec[1], vec[0])
//   busy             high while a run is in SETTLE or CHECK
//   done             high while in DONE
//   pass             valid with done; 1 when no vector mismatched
//   err_count        saturating count of failing vectors
//   first_fail_valid a mismatch has been captured during this run
//   first_fail_vec   vector of the first mismatch
//   first_fail_mask  result XOR golden at the first mismatch
module gate_vector_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [8:0]       result,
    output logic             input1,
    output logic             input2,
    output logic             input3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec,
    output logic [8:0]       first_fail_mask
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [2:0]       r_vec;
    logic [2:0]       w_vec_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] w_err_nx;
    logic [ERR_W-1:0] w_err_inc;
    logic             r_ffv;
    logic             w_ffv_nx;
    logic [2:0]       r_ffvec;
    logic [2:0]       w_ffvec_nx;
    logic [8:0]       r_ffmask;
    logic [8:0]       w_ffmask_nx;
    logic             r_pass;
    logic             w_pass_nx;
    logic             r_busy;
    logic             w_busy_nx;
    logic             r_done;
    logic             w_done_nx;
    logic [8:0]       w_golden;
    logic [8:0]       w_mask;
    logic             w_mis;

    function automatic logic [8:0] golden(input logic [2:0] v);
        logic a;
        logic b;
        logic c;
        a = v[2];
        b = v[1];
        c = v[0];
        golden = {a & b & c,
                  ~(a ^ b ^ c),
                  ~(a ^ b),
                  a ^ b,
                  ~(a | b),
                  a | b,
                  ~(a & b),
                  a & b,
                  ~a};
    endfunction

    assign w_golden  = golden(r_vec);
    assign w_mask    = result ^ w_golden;
    assign w_mis     = |w_mask;
    assign w_err_inc = (&r_err) ? r_err : r_err + 1'b1;

    always_comb begin
        w_state_nx  = r_state;
        w_vec_nx    = r_vec;
        w_cnt_nx    = r_cnt;
        w_err_nx    = r_err;
        w_ffv_nx    = r_ffv;
        w_ffvec_nx  = r_ffvec;
        w_ffmask_nx = r_ffmask;
        w_pass_nx   = r_pass;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nx  = S_SETTLE;
                    w_vec_nx    = 3'd0;
                    w_cnt_nx    = '0;
                    w_err_nx    = '0;
                    w_ffv_nx    = 1'b0;
                    w_ffvec_nx  = 3'd0;
                    w_ffmask_nx = 9'd0;
                    w_pass_nx   = 1'b0;
                end
            end
            S_SETTLE: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nx = S_CHECK;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (w_mis) begin
                    w_err_nx = w_err_inc;
                    if (!r_ffv) begin
                        w_ffv_nx    = 1'b1;
                        w_ffvec_nx  = r_vec;
                        w_ffmask_nx = w_mask;
                    end
                end
                if (r_vec == 3'd7) begin
                    w_state_nx = S_DONE;
                    // Includes the verdict of this final vector.
                    w_pass_nx  = !w_mis && (r_err == '0);
                end else begin
                    w_state_nx = S_SETTLE;
                    w_vec_nx   = r_vec + 3'd1;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx == S_SETTLE) || (w_state_nx == S_CHECK);
        w_done_nx = (w_state_nx == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_vec    <= 3'd0;
            r_cnt    <= '0;
            r_err    <= '0;
            r_ffv    <= 1'b0;
            r_ffvec  <= 3'd0;
            r_ffmask <= 9'd0;
            r_pass   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_vec    <= w_vec_nx;
            r_cnt    <= w_cnt_nx;
            r_err    <= w_err_nx;
            r_ffv    <= w_ffv_nx;
            r_ffvec  <= w_ffvec_nx;
            r_ffmask <= w_ffmask_nx;
            r_pass   <= w_pass_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    assign input1           = r_vec[2];
    assign input2           = r_vec[1];
    assign input3           = r_vec[0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;
    assign first_fail_mask  = r_ffmask;

endmodule
